// File: rtl/subtractor_serial_n_bit_if.sv
// Bus bundle for subtractor_serial_n_bit.
// Signals:
//   start        - request to begin one subtraction (driven by master)
//   in_a, in_b   - minuend / subtrahend, sampled on the accepting edge (master)
//   out          - difference in_a - in_b modulo 2^N (slave)
//   bout         - borrow out, 1 when unsigned in_a < in_b (slave)
//   ovf          - two's-complement overflow of the subtraction (slave)
//   busy         - high while bits are being processed (slave)
//   done         - one-cycle pulse, out/bout/ovf newly valid (slave)
// Modports: master (requester side), slave (subtractor side).
interface subtractor_serial_n_bit_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] out;
  logic         bout;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, in_a, in_b,
    input  out, bout, ovf, busy, done
  );

  modport slave (
    input  start, in_a, in_b,
    output out, bout, ovf, busy, done
  );
endinterface

// File: rtl/subtractor_serial_n_bit.sv
// Bit-serial N-bit subtractor.
// One subtraction is accepted in IDLE when start=1; the operands are then
// processed LSB first, one bit per clock, for N clocks (RUN), after which the
// result, final borrow and signed overflow are registered and done pulses for
// one cycle (DONE). Back-to-back throughput is one result per N+2 cycles.
// Ports:
//   clk   - clock, rising edge active
//   rst_n - asynchronous active-low reset
//   bus   - subtractor_serial_n_bit_if.slave: start, in_a, in_b in;
//           out, bout, ovf, busy, done out
module subtractor_serial_n_bit #(
  parameter int N = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  subtractor_serial_n_bit_if.slave  bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;

  // a_q doubles as the result register: every RUN edge shifts the operand
  // right and the new difference bit enters at the MSB, so after N edges
  // a_q holds the full difference.
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic          br_q;
  logic [CW-1:0] cnt_q;
  logic          a_msb_q;
  logic          b_msb_q;

  logic [N-1:0]  out_q;
  logic          bout_q;
  logic          ovf_q;

  logic          d_bit;
  logic          br_next;
  logic [N-1:0]  res_next;
  logic          last_bit;

  // One full-subtractor cell.
  function automatic logic diff_bit(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  function automatic logic borrow_bit(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

  always_comb begin
    d_bit    = diff_bit(a_q[0], b_q[0], br_q);
    br_next  = borrow_bit(a_q[0], b_q[0], br_q);
    res_next = {d_bit, a_q[N-1:1]};
    last_bit = (cnt_q == CW'(N - 1));
  end

  // Next-state and status outputs
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.out  = out_q;
    bus.bout = bout_q;
    bus.ovf  = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: operand capture, bit-serial shift, result registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      out_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= bus.in_a[N-1];
            b_msb_q <= bus.in_b[N-1];
          end
        end
        RUN: begin
          a_q   <= res_next;
          b_q   <= {1'b0, b_q[N-1:1]};
          br_q  <= br_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            out_q  <= res_next;
            bout_q <= br_next;
            // Overflow only possible when operand signs differ and the
            // result sign departs from the minuend sign.
            ovf_q  <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_serial_n_bit.sv
module tb_subtractor_serial_n_bit;
  localparam int N = 4;

  typedef struct {
    logic [N-1:0] o;
    logic         b;
    logic         v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  subtractor_serial_n_bit_if #(.N(N)) bus ();

  subtractor_serial_n_bit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and model state
  exp_t         sb[$];
  int           m_cnt;       // cycles remaining in the current operation
  logic         dir_valid;
  exp_t         dir_exp;
  logic [N-1:0] last_o;
  logic         last_b;
  logic         last_v;

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t ref_sub(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t r;
    int ua, ub, sa, sb_i, diff;
    ua   = int'(a);
    ub   = int'(b);
    sa   = a[N-1] ? ua - (1 << N) : ua;
    sb_i = b[N-1] ? ub - (1 << N) : ub;
    diff = sa - sb_i;
    r.o  = N'((ua - ub + (1 << N)) % (1 << N));
    r.b  = (ua < ub);
    r.v  = (diff > (1 << (N - 1)) - 1) || (diff < -(1 << (N - 1)));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: an accepted start occupies N RUN cycles + 1 DONE cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      sb.delete();
    end else if (m_cnt == 0) begin
      if (bus.start === 1'b1) begin
        sb.push_back(dir_valid ? dir_exp : ref_sub(bus.in_a, bus.in_b));
        m_cnt <= N + 1;
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      last_o <= '0;
      last_b <= 1'b0;
      last_v <= 1'b0;
    end else begin
      chk("busy", 32'(bus.busy), 32'(m_cnt >= 2));
      chk("done", 32'(bus.done), 32'(m_cnt == 1));
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(1), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out",  32'(bus.out),  32'(e.o));
          chk("bout", 32'(bus.bout), 32'(e.b));
          chk("ovf",  32'(bus.ovf),  32'(e.v));
          last_o <= e.o;
          last_b <= e.b;
          last_v <= e.v;
        end
      end else begin
        chk("out_hold",  32'(bus.out),  32'(last_o));
        chk("bout_hold", 32'(bus.bout), 32'(last_b));
        chk("ovf_hold",  32'(bus.ovf),  32'(last_v));
      end
    end
  end

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 4 * N + 10) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) chk(name, 32'(sb.size()), 32'(0));
  endtask

  // Directed op with spec-given expectation.
  task automatic run_dir(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eo, input logic eb, input logic ev);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_a  = a;
    bus.in_b  = b;
    dir_exp.o = eo;
    dir_exp.b = eb;
    dir_exp.v = ev;
    dir_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dir_valid = 1'b0;
    bus.in_a  = N'($urandom);
    bus.in_b  = N'($urandom);
    wait_drain("directed_timeout");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    dir_valid = 1'b0;
    dir_exp.o = '0;
    dir_exp.b = 1'b0;
    dir_exp.v = 1'b0;
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    rst_n     = 1'b0;

    // Reset state
    #3;
    chk("rst_out",  32'(bus.out),  32'(0));
    chk("rst_bout", 32'(bus.bout), 32'(0));
    chk("rst_ovf",  32'(bus.ovf),  32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Spec examples
    run_dir(4'b0111, 4'b0011, 4'b0100, 1'b0, 1'b0);
    run_dir(4'b0011, 4'b0100, 4'b1111, 1'b1, 1'b0);
    run_dir(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
    run_dir(4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1);
    run_dir(4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1);
    run_dir(4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0);

    // start held high: back-to-back, operands scrambled while busy
    for (int i = 0; i < 4 * (N + 2); i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      if (m_cnt == 0) begin
        bus.in_a = 4'b0101;
        bus.in_b = 4'b0010;
      end else begin
        bus.in_a = N'($urandom);
        bus.in_b = N'($urandom);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("hold_timeout");

    // Reset mid-RUN: between E2 and E3
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_a  = 4'b0111;
    bus.in_b  = 4'b0011;
    @(posedge clk);            // E0
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);            // E1
    @(posedge clk);            // E2
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out",  32'(bus.out),  32'(0));
    chk("abort_bout", 32'(bus.bout), 32'(0));
    chk("abort_ovf",  32'(bus.ovf),  32'(0));
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_done", 32'(bus.done), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_dir(4'b0111, 4'b0011, 4'b0100, 1'b0, 1'b0);

    // Random traffic: random start, operands changing every cycle
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) != 0);
      bus.in_a  = N'($urandom);
      bus.in_b  = N'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain("final_timeout");
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/subtractor_serial_n_bit.md
SUBTRACTOR_SERIAL_N_BIT -- requirements
Module: subtractor_serial_n_bit

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand and result width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin one subtraction.
REQ-005 The block SHALL have port in_a, input, N bits, minuend, sampled only on the accepting edge.
REQ-006 The block SHALL have port in_b, input, N bits, subtrahend, sampled only on the accepting edge.
REQ-007 The block SHALL have port out, output, N bits, difference in_a - in_b modulo 2^N.
REQ-008 The block SHALL have port bout, output, 1 bit, borrow out (1 when unsigned in_a < in_b).
REQ-009 The block SHALL have port ovf, output, 1 bit, two's-complement signed overflow of the subtraction.
REQ-010 The block SHALL have port busy, output, 1 bit, high while bits are being processed.
REQ-011 The block SHALL have port done, output, 1 bit, one-cycle pulse marking out/bout/ovf as newly valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 In IDLE, a rising edge with start=1 SHALL latch in_a and in_b into internal shift registers, clear the internal borrow to 0, clear the bit counter to 0, and move to RUN.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE.
REQ-015 Each RUN edge SHALL process one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-016 Each RUN edge SHALL shift d into the MSB of an internal result register, shifting it right; both operand registers SHALL shift right by one.
REQ-017 After exactly N RUN edges, the FSM SHALL move to DONE.
REQ-018 On that same edge, out SHALL load the full result, bout SHALL load the final borrow, and ovf SHALL load (a_msb != b_msb) && (out_msb != a_msb), using the latched operand MSBs.
REQ-019 DONE SHALL last exactly one cycle, followed unconditionally by IDLE.
REQ-020 busy SHALL be 1 exactly when the state is RUN.
REQ-021 done SHALL be 1 exactly when the state is DONE.
REQ-022 Latency: with start accepted at edge E0, busy SHALL be high from E0 to EN, and done SHALL be high from EN to EN+1.
REQ-023 out, bout and ovf SHALL hold their values from the last completed operation until the next transition into DONE; they SHALL NOT change during RUN.
REQ-024 start SHALL be ignored in RUN and DONE, with no queuing; in_a and in_b changes after the accepting edge SHALL NOT affect the result.
REQ-025 start=1 in the IDLE cycle following DONE SHALL be accepted, giving back-to-back throughput of one result per N+2 cycles.
REQ-026 Wrap-around SHALL be modulo 2^N, for example 0 - 1 gives all ones with bout=1.

Reset
REQ-027 While rst_n=0, regardless of clk: state SHALL be IDLE; out, bout, ovf, busy and done SHALL be 0; internal registers and the counter SHALL be 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first edge after rst_n rises SHALL be able to accept start.

Verification (N=4; start sampled at E0)
REQ-029 a=0111, b=0011, start pulse -> busy E0..E4; done E4..E5; out=0100, bout=0, ovf=0.
REQ-030 a=0011, b=0100 -> out=1111, bout=1, ovf=0; a=1111, b=1111 -> out=0000, bout=0, ovf=0.
REQ-031 a=1000, b=0001 -> out=0111, bout=0, ovf=1; a=0111, b=1000 -> out=1111, bout=1, ovf=1.
REQ-032 start held high continuously with a=0101, b=0010 -> done pulses every 6 cycles, each with out=0011; operand changes during RUN do not alter the result.
REQ-033 rst_n low between E2 and E3 -> all outputs 0 immediately; no done pulse; a fresh start afterwards completes normally with the correct result.
